// File: rtl/nonce_sweep_pkg.sv
// Shared types for the nonce sweep controller: FSM state encoding, nonce
// width and the entry carried through the hit-attribution delay line.
package nonce_sweep_pkg;

  localparam int NONCE_W   = 32;
  localparam int MAX_LANES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // lane_en is sized for the widest supported lane count; narrower builds
  // use the low NUM_LANES bits only.
  typedef struct packed {
    logic                 valid;
    logic [NONCE_W-1:0]   base;
    logic [MAX_LANES-1:0] lane_en;
  } dl_entry_t;

endpackage

// File: rtl/nonce_sweep_fifo.sv
// Golden-nonce result FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; otherwise it is discarded. Read data is
// forced to zero while empty so the output port stays clean after reset.
module nonce_sweep_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep controller: issues NUM_LANES consecutive nonces per cycle over
// an inclusive, wrap-capable range, attributes returning hits through a
// PIPE_LAT-deep delay line and queues golden nonces in a small FIFO.
// Optional build macro NONCE_SWEEP_DROP_CNT_EN adds a saturating drop_cnt
// output counting hits that were discarded.
//
// state | meaning
// IDLE  | no sweep; waiting for start
// SWEEP | issuing one lane group per cycle
// DRAIN | waiting PIPE_LAT cycles for in-flight hits
// DONE  | sweep finished; done held until next start
module nonce_sweep_ctrl
  import nonce_sweep_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int PIPE_LAT   = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NONCE_W-1:0]           nonce_first,
  input  logic [NONCE_W-1:0]           nonce_last,
  output logic                         busy,
  output logic                         done,
  output logic                         issue_valid,
  output logic [NONCE_W*NUM_LANES-1:0] issue_nonce,
  output logic [NUM_LANES-1:0]         issue_lane_en,
  input  logic [NUM_LANES-1:0]         hit,
  output logic                         gn_valid,
  output logic [NONCE_W-1:0]           gn_nonce,
  input  logic                         gn_ready
`ifdef NONCE_SWEEP_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t               state_q, state_d;
  logic [NONCE_W-1:0]   base_q;
  logic [NONCE_W:0]     rem_q;
  logic [CW-1:0]        drain_q;
  logic                 start_ok, last_grp;
  logic [NUM_LANES-1:0] lane_en_w, qual;
  dl_entry_t            dl [PIPE_LAT];
  dl_entry_t            new_ent, dl_out;
  logic                 push, pop, fifo_full, fifo_empty;
  logic [NONCE_W-1:0]   push_nonce;

  assign start_ok = start & ~abort & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign last_grp = (rem_q <= (NONCE_W+1)'(NUM_LANES));
  assign dl_out   = dl[PIPE_LAT-1];

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // next-state logic; abort overrides everything including start
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_ok) state_d = ST_SWEEP;
      ST_SWEEP:         if (last_grp) state_d = ST_DRAIN;
      ST_DRAIN:         if (drain_q == '0) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // lanes still inside the remaining range
  always_comb begin
    lane_en_w = '0;
    for (int k = 0; k < NUM_LANES; k++) lane_en_w[k] = (rem_q > (NONCE_W+1)'(k));
  end

  // FSM outputs and issue bus
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    issue_valid   = 1'b0;
    issue_nonce   = '0;
    issue_lane_en = '0;
    case (state_q)
      ST_SWEEP: begin
        busy          = 1'b1;
        issue_valid   = 1'b1;
        issue_lane_en = lane_en_w;
        for (int k = 0; k < NUM_LANES; k++)
          issue_nonce[k*NONCE_W +: NONCE_W] = base_q + NONCE_W'(k);
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // range latch, group base/remaining count and drain down-counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q  <= '0;
      rem_q   <= '0;
      drain_q <= '0;
    end else if (start_ok) begin
      base_q <= nonce_first;
      rem_q  <= {1'b0, nonce_last - nonce_first} + (NONCE_W+1)'(1);
    end else if (state_q == ST_SWEEP && !abort) begin
      base_q  <= base_q + NONCE_W'(NUM_LANES);
      rem_q   <= last_grp ? '0 : rem_q - (NONCE_W+1)'(NUM_LANES);
      drain_q <= CW'(PIPE_LAT-1);
    end else if (state_q == ST_DRAIN && drain_q != '0) begin
      drain_q <= drain_q - CW'(1);
    end
  end

  // delay-line entry for the group issued this cycle
  always_comb begin
    new_ent                         = '0;
    new_ent.valid                   = issue_valid;
    new_ent.base                    = base_q;
    new_ent.lane_en[NUM_LANES-1:0]  = issue_lane_en;
  end

  // delay line; abort wipes everything in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || abort) begin
      if (!reset_n) begin
        for (int i = 0; i < PIPE_LAT; i++) dl[i] <= '0;
      end else begin
        for (int i = 0; i < PIPE_LAT; i++) dl[i] <= '0;
      end
    end else begin
      dl[0] <= new_ent;
      for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  // hit attribution: lowest qualified lane wins
  always_comb begin
    qual       = hit & dl_out.lane_en[NUM_LANES-1:0] & {NUM_LANES{dl_out.valid}};
    push       = 1'b0;
    push_nonce = '0;
    for (int k = NUM_LANES-1; k >= 0; k--) begin
      if (qual[k]) begin
        push       = 1'b1;
        push_nonce = dl_out.base + NONCE_W'(k);
      end
    end
    if (abort) push = 1'b0;
  end

  assign pop      = gn_valid & gn_ready;
  assign gn_valid = ~fifo_empty;

  nonce_sweep_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (push_nonce),
    .pop     (pop),
    .rdata   (gn_nonce),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef NONCE_SWEEP_DROP_CNT_EN
  logic [3:0]  drop_inc;
  logic [16:0] drop_sum;

  // hits lost this cycle: same-cycle losers plus a winner refused by a full FIFO
  always_comb begin
    drop_inc = '0;
    for (int k = 0; k < NUM_LANES; k++) drop_inc = drop_inc + 4'(qual[k]);
    if (push) begin
      drop_inc = drop_inc - 4'd1;
      if (fifo_full && !pop) drop_inc = drop_inc + 4'd1;
    end
    if (abort) drop_inc = '0;
  end

  assign drop_sum = {1'b0, drop_cnt} + {13'd0, drop_inc};

  // saturating drop counter, cleared by an accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      drop_cnt <= '0;
    else if (start_ok) drop_cnt <= '0;
    else               drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`else
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;
`endif

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Self-checking bench for nonce_sweep_ctrl (NUM_LANES=4, PIPE_LAT=8, FIFO_DEPTH=4).
// Expected golden nonces are queued when hits are scheduled and popped when
// the DUT hands a result over the gn_valid/gn_ready stream.
module tb_nonce_sweep_ctrl;

  localparam int L  = 4;
  localparam int PL = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, gn_ready = 1'b0;
  logic [31:0]   nonce_first = '0, nonce_last = '0;
  logic          busy, done, issue_valid, gn_valid;
  logic [32*L-1:0] issue_nonce;
  logic [L-1:0]  issue_lane_en;
  logic [L-1:0]  hit = '0;
  logic [31:0]   gn_nonce;
`ifdef NONCE_SWEEP_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int            n_checks = 0, n_pass = 0, cyc_cnt = 0;
  logic [3:0]    hit_sched [int];
  logic [31:0]   exp_q [$];

  nonce_sweep_ctrl #(.NUM_LANES(L), .PIPE_LAT(PL), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .nonce_first(nonce_first), .nonce_last(nonce_last),
    .busy(busy), .done(done), .issue_valid(issue_valid),
    .issue_nonce(issue_nonce), .issue_lane_en(issue_lane_en), .hit(hit),
    .gn_valid(gn_valid), .gn_nonce(gn_nonce), .gn_ready(gn_ready)
`ifdef NONCE_SWEEP_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt = cyc_cnt + 1;

  always @(negedge clk) hit = hit_sched.exists(cyc_cnt) ? hit_sched[cyc_cnt] : 4'b0000;

  // scoreboard: every handshake must match the oldest expected nonce
  always @(negedge clk) begin
    logic [31:0] ev;
    if (reset_n === 1'b1 && gn_valid === 1'b1 && gn_ready === 1'b1) begin
      n_checks = n_checks + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected got=%h expected=none", gn_nonce);
      end else begin
        ev = exp_q.pop_front();
        if (gn_nonce !== ev) $display("FAIL sb_result got=%h expected=%h", gn_nonce, ev);
        else n_pass = n_pass + 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sched_hit(input int cyc, input logic [3:0] pat);
    hit_sched[cyc] = pat;
  endtask

  // start a sweep, check every issued group against the range model and
  // check that done rises PIPE_LAT+1 cycles after the final issue
  task automatic run_sweep(input logic [31:0] first, input logic [31:0] last,
                           input string tag);
    logic [32:0] rem;
    logic [31:0] b;
    logic [3:0]  en;
    bit          ok;
    int          ng, exp_ng, last_issue;
    rem = {1'b0, last - first} + 33'd1;
    exp_ng = int'((rem + 33'd3) >> 2);
    b = first; ng = 0; last_issue = cyc_cnt;
    nonce_first = first; nonce_last = last;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (issue_valid !== 1'b1) break;
      en = '0;
      for (int k = 0; k < L; k++) en[k] = (rem > 33'(k));
      n_checks++;
      if (issue_lane_en !== en)
        $display("FAIL %s lane_en grp=%0d got=%b expected=%b", tag, ng, issue_lane_en, en);
      else n_pass++;
      ok = 1'b1;
      for (int k = 0; k < L; k++) if (issue_nonce[32*k +: 32] !== b + 32'(k)) ok = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL %s issue_nonce grp=%0d got=%h base_expected=%h", tag, ng, issue_nonce, b);
      else n_pass++;
      rem = (rem > 33'd4) ? rem - 33'd4 : 33'd0;
      b = b + 32'd4; ng++; last_issue = cyc_cnt;
      tick();
    end
    n_checks++;
    if (ng != exp_ng) $display("FAIL %s groups got=%0d expected=%0d", tag, ng, exp_ng);
    else n_pass++;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) break;
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || cyc_cnt - last_issue != PL + 1)
      $display("FAIL %s drain_len got=%0d done=%b expected=%0d", tag, cyc_cnt - last_issue, done, PL + 1);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s done_hold got done=%b busy=%b expected done=1 busy=0", tag, done, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, issue_valid, gn_valid} !== 4'b0 || issue_nonce !== '0 ||
        issue_lane_en !== '0 || gn_nonce !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b iv=%b gv=%b in=%h en=%b gn=%h expected all 0",
               busy, done, issue_valid, gn_valid, issue_nonce, issue_lane_en, gn_nonce);
    else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    tick();
    n_checks++;
    if ({busy, done, issue_valid, gn_valid} !== 4'b0)
      $display("FAIL post_reset got busy=%b done=%b iv=%b gv=%b expected 0", busy, done, issue_valid, gn_valid);
    else n_pass++;
  endtask

  task automatic test_sweep_basic();
    int g0;
    gn_ready = 1'b1;
    g0 = cyc_cnt + 1;
    sched_hit(g0 + 63 + PL, 4'b0100); exp_q.push_back(32'h0E333378);
    sched_hit(g0 + 64 + PL, 4'b0001); exp_q.push_back(32'h0E33337A);
    run_sweep(32'h0E33337A - 32'd256, 32'h0E33337A + 32'd3, "basic");
    tick(); tick();
    n_checks++;
    if (exp_q.size() != 0 || gn_valid !== 1'b0)
      $display("FAIL basic_results got pending=%0d gv=%b expected 0", exp_q.size(), gn_valid);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int g0;
    gn_ready = 1'b1;
    g0 = cyc_cnt + 1;
    sched_hit(g0 + PL, 4'b0100);     exp_q.push_back(32'h00000000);
    sched_hit(g0 + 1 + PL, 4'b1100);
    run_sweep(32'hFFFFFFFE, 32'h00000003, "wrap");
    tick(); tick();
    n_checks++;
    if (exp_q.size() != 0 || gn_valid !== 1'b0)
      $display("FAIL wrap_results got pending=%0d gv=%b expected 0", exp_q.size(), gn_valid);
    else n_pass++;
`ifdef NONCE_SWEEP_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd0) $display("FAIL wrap_drop_cnt got=%0d expected=0", drop_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_multi_hit();
    int g0;
    gn_ready = 1'b1;
    g0 = cyc_cnt + 1;
    sched_hit(g0 + 1 + PL, 4'b1010); exp_q.push_back(32'h00000105);
    run_sweep(32'h00000100, 32'h0000010F, "multi");
    tick(); tick();
    n_checks++;
    if (exp_q.size() != 0 || gn_valid !== 1'b0)
      $display("FAIL multi_results got pending=%0d gv=%b expected 0", exp_q.size(), gn_valid);
    else n_pass++;
`ifdef NONCE_SWEEP_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd1) $display("FAIL multi_drop_cnt got=%0d expected=1", drop_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_fifo_full();
    int g0, g1, guard;
    gn_ready = 1'b0;
    g0 = cyc_cnt + 1;
    for (int g = 0; g < 6; g++) begin
      sched_hit(g0 + g + PL, 4'b0001);
      if (g < 4) exp_q.push_back(32'h00002000 + 32'(4 * g));
    end
    run_sweep(32'h00002000, 32'h0000201F, "full");
    n_checks++;
    if (gn_valid !== 1'b1 || gn_nonce !== 32'h00002000)
      $display("FAIL full_head got gv=%b gn=%h expected gv=1 gn=00002000", gn_valid, gn_nonce);
    else n_pass++;
`ifdef NONCE_SWEEP_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd2) $display("FAIL full_drop_cnt got=%0d expected=2", drop_cnt);
    else n_pass++;
`endif
    nonce_first = 32'h00003000; nonce_last = 32'h00003003;
    g1 = cyc_cnt + 1;
    sched_hit(g1 + PL, 4'b0001); exp_q.push_back(32'h00003000);
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (cyc_cnt < g1 + PL && guard < 50) begin tick(); guard++; end
    gn_ready = 1'b1; tick(); gn_ready = 1'b0;
    n_checks++;
    if (gn_valid !== 1'b1 || gn_nonce !== 32'h00002004)
      $display("FAIL full_pushpop got gv=%b gn=%h expected gv=1 gn=00002004", gn_valid, gn_nonce);
    else n_pass++;
`ifdef NONCE_SWEEP_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd0) $display("FAIL full_pushpop_drop got=%0d expected=0", drop_cnt);
    else n_pass++;
`endif
    gn_ready = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (exp_q.size() != 0 || gn_valid !== 1'b0)
      $display("FAIL full_drain got pending=%0d gv=%b expected 0", exp_q.size(), gn_valid);
    else n_pass++;
  endtask

  task automatic test_abort();
    int g0, guard;
    gn_ready = 1'b0;
    g0 = cyc_cnt + 1;
    sched_hit(g0 + PL, 4'b0001); exp_q.push_back(32'h00004000);
    sched_hit(g0 + 10 + PL, 4'b0001);
    sched_hit(g0 + 11 + PL, 4'b0010);
    nonce_first = 32'h00004000; nonce_last = 32'h000040FF;
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (cyc_cnt < g0 + 12 && guard < 50) begin tick(); guard++; end
    n_checks++;
    if (issue_valid !== 1'b1) $display("FAIL abort_presweep got iv=%b expected 1", issue_valid);
    else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
    n_checks++;
    if ({busy, done, issue_valid} !== 3'b000)
      $display("FAIL abort_idle got busy=%b done=%b iv=%b expected 000", busy, done, issue_valid);
    else n_pass++;
    repeat (12) tick();
    n_checks++;
    if (gn_valid !== 1'b1 || gn_nonce !== 32'h00004000)
      $display("FAIL abort_retained got gv=%b gn=%h expected gv=1 gn=00004000", gn_valid, gn_nonce);
    else n_pass++;
`ifdef NONCE_SWEEP_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd0) $display("FAIL abort_drop_cnt got=%0d expected=0", drop_cnt);
    else n_pass++;
`endif
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || issue_valid !== 1'b0)
      $display("FAIL abort_wins got busy=%b iv=%b expected 0", busy, issue_valid);
    else n_pass++;
    gn_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (exp_q.size() != 0 || gn_valid !== 1'b0)
      $display("FAIL abort_drain got pending=%0d gv=%b expected 0", exp_q.size(), gn_valid);
    else n_pass++;
  endtask

  task automatic test_reset_drain();
    int g0, g1, guard;
    gn_ready = 1'b0;
    g0 = cyc_cnt + 1;
    sched_hit(g0 + PL, 4'b0001);
    run_sweep(32'h00005000, 32'h00005003, "prefill");
    n_checks++;
    if (gn_valid !== 1'b1 || gn_nonce !== 32'h00005000)
      $display("FAIL prefill got gv=%b gn=%h expected gv=1 gn=00005000", gn_valid, gn_nonce);
    else n_pass++;
    nonce_first = 32'h00006000; nonce_last = 32'h00006003;
    g1 = cyc_cnt + 1;
    sched_hit(g1 + PL, 4'b0001);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b1 || issue_valid !== 1'b0)
      $display("FAIL drain_state got busy=%b iv=%b expected busy=1 iv=0", busy, issue_valid);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, issue_valid, gn_valid} !== 4'b0 || issue_nonce !== '0 ||
        issue_lane_en !== '0 || gn_nonce !== '0)
      $display("FAIL rst_drain_outputs got busy=%b done=%b iv=%b gv=%b gn=%h expected all 0",
               busy, done, issue_valid, gn_valid, gn_nonce);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    guard = 0;
    while (cyc_cnt <= g1 + PL + 2 && guard < 50) begin tick(); guard++; end
    n_checks++;
    if ({busy, done, gn_valid} !== 3'b000)
      $display("FAIL rst_no_results got busy=%b done=%b gv=%b expected 000", busy, done, gn_valid);
    else n_pass++;
`ifdef NONCE_SWEEP_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd0) $display("FAIL rst_drop_cnt got=%0d expected=0", drop_cnt);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_sweep_basic();
    test_wrap();
    test_multi_hit();
    test_fifo_full();
    test_abort();
    test_reset_drain();
    gn_ready = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d expected=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
